// File: rtl/aes_req_arbiter_pkg.sv
// Shared state encoding, requester index type and helpers for the AES request arbiter.
package aes_req_arbiter_pkg;

    localparam int unsigned MAX_REQ   = 8;
    localparam int unsigned IDX_W     = $clog2(MAX_REQ);
    localparam int unsigned JOB_CNT_W = 16;

    typedef logic [IDX_W-1:0] idx_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FWD   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // Round-robin successor of a requester index among n requesters.
    function automatic idx_t next_idx(input idx_t cur, input int unsigned n);
        return ((32'(cur) + 32'd1) >= n) ? '0 : idx_t'(cur + idx_t'(1));
    endfunction

endpackage

// File: rtl/aes_req_arbiter_if.sv
// Stream bundle between requesters, the arbiter and the AES controller FIFOs.
interface aes_req_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 128,
    parameter int unsigned CMD_W   = 32
);
    logic [NUM_REQ-1:0]        req_tvalid;
    logic [NUM_REQ-1:0]        req_tready;
    logic [NUM_REQ-1:0]        req_tlast;
    logic [NUM_REQ*DATA_W-1:0] req_tdata;
    logic [NUM_REQ*CMD_W-1:0]  req_cmd;

    logic                      ctl_tvalid;
    logic                      ctl_tready;
    logic [DATA_W-1:0]         ctl_tdata;
    logic [CMD_W-1:0]          ctl_cmd;
    logic                      ctl_done;

    logic                      res_tvalid;
    logic                      res_tready;
    logic [DATA_W-1:0]         res_tdata;

    logic [NUM_REQ-1:0]        rsp_tvalid;
    logic [NUM_REQ-1:0]        rsp_tready;
    logic [DATA_W-1:0]         rsp_tdata;

    // Arbiter side
    modport slave (
        input  req_tvalid, req_tlast, req_tdata, req_cmd,
        input  ctl_tready, ctl_done,
        input  res_tvalid, res_tdata,
        input  rsp_tready,
        output req_tready,
        output ctl_tvalid, ctl_tdata, ctl_cmd,
        output res_tready,
        output rsp_tvalid, rsp_tdata
    );

    // Requesters plus controller side
    modport master (
        output req_tvalid, req_tlast, req_tdata, req_cmd,
        output ctl_tready, ctl_done,
        output res_tvalid, res_tdata,
        output rsp_tready,
        input  req_tready,
        input  ctl_tvalid, ctl_tdata, ctl_cmd,
        input  res_tready,
        input  rsp_tvalid, rsp_tdata
    );

endinterface

// File: rtl/aes_req_arbiter_rr_pick.sv
// Round-robin pick: first requesting bit at or after ptr, wrapping; one-hot, index and any-flag.
module aes_req_arbiter_rr_pick
    import aes_req_arbiter_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] req,
    input  idx_t         ptr,
    output logic [N-1:0] onehot,
    output idx_t         idx,
    output logic         any
);

    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (!any && req[i] && (((32'(ptr) + k) % N) == i)) begin
                    any       = 1'b1;
                    onehot[i] = 1'b1;
                    idx       = idx_t'(i);
                end
            end
        end
    end

endmodule

// File: rtl/aes_req_arbiter.sv
// Grants one requester at a time to the AES controller for a whole job (beats in, results out)
// and returns the controller's result stream to that requester.
module aes_req_arbiter
    import aes_req_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 128,
    parameter int unsigned CMD_W   = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    aes_req_arbiter_if.slave     bus,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 busy,
    output logic                 proto_err,
    output logic [JOB_CNT_W-1:0] job_cnt
);

    state_e             state;
    idx_t               grant_idx;
    idx_t               rr_ptr;

    logic [NUM_REQ-1:0] pick_oh;
    idx_t               pick_idx;
    logic               pick_any;
    logic [CMD_W-1:0]   pick_cmd;

    logic               sel_valid;
    logic               sel_last;
    logic               sel_rsp_ready;
    logic [DATA_W-1:0]  sel_data;
    logic               fwd;
    logic               active;
    logic               beat_fire;

    aes_req_arbiter_rr_pick #(.N(NUM_REQ)) u_rr_pick (
        .req    (bus.req_tvalid),
        .ptr    (rr_ptr),
        .onehot (pick_oh),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // One-hot muxes: winner's command at arbitration, owner's stream while granted
    always_comb begin
        pick_cmd      = '0;
        sel_valid     = 1'b0;
        sel_last      = 1'b0;
        sel_rsp_ready = 1'b0;
        sel_data      = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (pick_oh[i]) begin
                pick_cmd = bus.req_cmd[i*CMD_W +: CMD_W];
            end
            if (grant[i]) begin
                sel_valid     = bus.req_tvalid[i];
                sel_last      = bus.req_tlast[i];
                sel_rsp_ready = bus.rsp_tready[i];
                sel_data      = bus.req_tdata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign fwd       = (state == ST_FWD);
    assign active    = (state != ST_IDLE);
    assign beat_fire = fwd & sel_valid & bus.ctl_tready;

    // Zero-latency pass-through of both streams for the current owner only
    assign bus.req_tready = fwd ? (grant & {NUM_REQ{bus.ctl_tready}}) : '0;
    assign bus.ctl_tvalid = fwd & sel_valid;
    assign bus.ctl_tdata  = fwd ? sel_data : '0;
    assign bus.rsp_tvalid = active ? (grant & {NUM_REQ{bus.res_tvalid}}) : '0;
    assign bus.rsp_tdata  = bus.res_tdata;
    assign bus.res_tready = active & sel_rsp_ready;

    // Job sequencing: only tlast followed by ctl_done releases the grant
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            grant       <= '0;
            grant_idx   <= '0;
            rr_ptr      <= '0;
            bus.ctl_cmd <= '0;
            proto_err   <= 1'b0;
            job_cnt     <= '0;
            busy        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.ctl_done) begin
                        proto_err <= 1'b1;
                    end
                    if (pick_any) begin
                        state       <= ST_FWD;
                        grant       <= pick_oh;
                        grant_idx   <= pick_idx;
                        bus.ctl_cmd <= pick_cmd;
                        busy        <= 1'b1;
                    end
                end
                ST_FWD: begin
                    if (bus.ctl_done) begin
                        proto_err <= 1'b1;
                    end
                    if (beat_fire && sel_last) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (bus.ctl_done) begin
                        state   <= ST_IDLE;
                        grant   <= '0;
                        busy    <= 1'b0;
                        rr_ptr  <= next_idx(grant_idx, NUM_REQ);
                        job_cnt <= job_cnt + JOB_CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_req_arbiter.sv
// Randomized scoreboard bench for aes_req_arbiter: requester and controller models drive the bus,
// a monitor pops expected ctl/rsp beats computed from a round-robin job-order model.
module tb_aes_req_arbiter;

    localparam int unsigned NR   = 4;
    localparam int unsigned DW   = 128;
    localparam int unsigned CW   = 32;
    localparam int unsigned MAXB = 4;

    typedef struct {
        logic [NR-1:0] oh;
        logic [CW-1:0] cmd;
        logic [DW-1:0] data;
        logic          last;
    } ctl_exp_t;

    typedef struct {
        logic [NR-1:0] oh;
        logic [DW-1:0] data;
    } rsp_exp_t;

    logic          clk;
    logic          reset;
    logic [NR-1:0] grant;
    logic          busy;
    logic          proto_err;
    logic [15:0]   job_cnt;

    aes_req_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW), .CMD_W(CW)) bus ();

    aes_req_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .CMD_W(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.slave),
        .grant     (grant),
        .busy      (busy),
        .proto_err (proto_err),
        .job_cnt   (job_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    ctl_exp_t exp_ctl[$];
    rsp_exp_t exp_rsp[$];

    // Requester job state
    logic [DW-1:0] jb [NR][MAXB];
    logic [CW-1:0] jcmd [NR];
    int            jlen [NR];
    int            jidx [NR];
    bit            jact [NR];

    // Controller model state
    logic [DW-1:0] res_q[$];
    int            beat_no;
    bit            got_last;
    bit            hold_done;
    int            stall;

    // Reference model state
    int            model_ptr;
    int            model_cnt;
    bit            model_perr;
    bit            done_probe;
    bit            done_prev;
    logic [NR-1:0] owner_model;
    bit            in_drain;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name, input int act, input int exp);
        checks++;
        errors++;
        $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic logic [DW-1:0] rnd_data();
        logic [DW-1:0] v;
        for (int w = 0; w < DW/32; w++) v[w*32 +: 32] = $urandom;
        return v;
    endfunction

    // Result transform applied by the controller model to every non-key beat
    function automatic logic [DW-1:0] xform(input logic [DW-1:0] x);
        return {x[DW-9:0], x[DW-1:DW-8]} ^ {(DW/32){32'h5A3C_96E1}};
    endfunction

    // One clock: sample handshakes away from the edge, then update all bench-driven inputs
    task automatic step();
        logic [NR-1:0] rq_fire;
        logic          ctl_fire;
        logic          res_fire;
        logic [DW-1:0] ctl_d;
        logic [CW-1:0] ctl_c;
        @(negedge clk);
        rq_fire  = bus.req_tvalid & bus.req_tready;
        ctl_fire = bus.ctl_tvalid & bus.ctl_tready;
        res_fire = bus.res_tvalid & bus.res_tready;
        ctl_d    = bus.ctl_tdata;
        ctl_c    = bus.ctl_cmd;
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (rq_fire[i]) jidx[i]++;
            if (jact[i] && jidx[i] >= jlen[i]) jact[i] = 1'b0;
            if (!jact[i]) begin
                bus.req_tvalid[i] = 1'b0;
                bus.req_tlast[i]  = 1'b0;
            end else begin
                if (!(bus.req_tvalid[i] && !rq_fire[i]))
                    bus.req_tvalid[i] = (jidx[i] == 0) || ($urandom_range(0, 3) != 0);
                bus.req_tdata[i*DW +: DW] = jb[i][jidx[i]];
                bus.req_tlast[i]          = (jidx[i] == jlen[i] - 1);
            end
        end
        if (ctl_fire) begin
            if (beat_no > 0) res_q.push_back(xform(ctl_d));
            beat_no++;
            if (beat_no == int'(ctl_c[3:0])) got_last = 1'b1;
        end
        if (res_fire) void'(res_q.pop_front());
        bus.ctl_done = 1'b0;
        if (got_last && res_q.size() == 0 && !hold_done) begin
            bus.ctl_done = 1'b1;
            got_last     = 1'b0;
            beat_no      = 0;
        end
        if (res_q.size() == 0) bus.res_tvalid = 1'b0;
        else if (!(bus.res_tvalid && !res_fire)) bus.res_tvalid = ($urandom_range(0, 3) != 0);
        if (res_q.size() != 0) bus.res_tdata = res_q[0];
        if (stall > 0) begin
            stall--;
            bus.ctl_tready = 1'b0;
        end else if ($urandom_range(0, 19) == 0) begin
            stall = 4;
            bus.ctl_tready = 1'b0;
        end else begin
            bus.ctl_tready = ($urandom_range(0, 4) != 0);
        end
        bus.rsp_tready = NR'($urandom);
    endtask

    // Issue one job per requester in mask; expected order comes from the round-robin rule
    task automatic run_round(input logic [NR-1:0] mask, input int fixed_len, input bit hold);
        logic [NR-1:0] left;
        int            g;
        int            n;
        int            target;
        int            c;
        n         = 0;
        hold_done = hold;
        for (int i = 0; i < NR; i++) begin
            if (mask[i]) begin
                jlen[i] = (fixed_len > 0) ? fixed_len : int'($urandom_range(1, MAXB));
                jcmd[i] = ($urandom & 32'hFFFF_FFF0) | CW'(jlen[i]);
                for (int b = 0; b < MAXB; b++) jb[i][b] = rnd_data();
                jidx[i] = 0;
                jact[i] = 1'b1;
                bus.req_cmd[i*CW +: CW] = jcmd[i];
            end
        end
        left = mask;
        while (left != '0) begin
            g = -1;
            for (int k = 0; k < NR; k++)
                if (g < 0 && left[(model_ptr + k) % NR]) g = (model_ptr + k) % NR;
            left[g]   = 1'b0;
            model_ptr = (g + 1) % NR;
            n++;
            for (int b = 0; b < jlen[g]; b++) begin
                exp_ctl.push_back('{oh: NR'(1) << g, cmd: jcmd[g], data: jb[g][b],
                                    last: (b == jlen[g] - 1)});
                if (b > 0) exp_rsp.push_back('{oh: NR'(1) << g, data: xform(jb[g][b])});
            end
        end
        target = model_cnt + n;
        c = 0;
        if (!hold) begin
            while (model_cnt < target && c < 3000) begin step(); c++; end
            if (model_cnt < target) fail("round_timeout", model_cnt, target);
            check("ctl_all_seen", DW'(exp_ctl.size()), '0);
            check("rsp_all_seen", DW'(exp_rsp.size()), '0);
        end else begin
            while (!(got_last && res_q.size() == 0) && c < 3000) begin step(); c++; end
            if (!got_last) fail("drain_timeout", 0, 1);
        end
    endtask

    task automatic clear_env();
        for (int i = 0; i < NR; i++) jact[i] = 1'b0;
        bus.req_tvalid = '0;
        bus.req_tlast  = '0;
        bus.req_tdata  = '0;
        bus.req_cmd    = '0;
        bus.ctl_tready = 1'b0;
        bus.ctl_done   = 1'b0;
        bus.res_tvalid = 1'b0;
        bus.res_tdata  = '0;
        bus.rsp_tready = '0;
        res_q.delete();
        exp_ctl.delete();
        exp_rsp.delete();
        beat_no     = 0;
        got_last    = 1'b0;
        hold_done   = 1'b0;
        stall       = 0;
        model_ptr   = 0;
        model_cnt   = 0;
        model_perr  = 1'b0;
        done_probe  = 1'b0;
        owner_model = '0;
        in_drain    = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_grant"},      DW'(grant), '0);
        check({tag, "_busy"},       DW'(busy), '0);
        check({tag, "_proto_err"},  DW'(proto_err), '0);
        check({tag, "_job_cnt"},    DW'(job_cnt), '0);
        check({tag, "_ctl_cmd"},    DW'(bus.ctl_cmd), '0);
        check({tag, "_req_tready"}, DW'(bus.req_tready), '0);
        check({tag, "_ctl_tvalid"}, DW'(bus.ctl_tvalid), '0);
        check({tag, "_rsp_tvalid"}, DW'(bus.rsp_tvalid), '0);
        check({tag, "_res_tready"}, DW'(bus.res_tready), '0);
    endtask

    // Monitor: invariants on the owner routing, then scoreboard pops on each handshake
    always @(negedge clk) begin
        ctl_exp_t ce;
        rsp_exp_t re;
        if (reset) begin
            done_prev = 1'b0;
        end else begin
            if (done_prev) begin
                model_cnt++;
                check("job_cnt",   DW'(job_cnt), DW'(16'(model_cnt)));
                check("rel_grant", DW'(grant), '0);
                check("rel_busy",  DW'(busy), '0);
                check("proto_err", DW'(proto_err), DW'(model_perr));
                owner_model = '0;
                in_drain    = 1'b0;
            end
            done_prev = bus.ctl_done && !done_probe;
            if (owner_model != '0)
                check("req_tready", DW'(bus.req_tready),
                      DW'(in_drain ? '0 : (owner_model & {NR{bus.ctl_tready}})));
            if (bus.res_tvalid && owner_model != '0) begin
                check("rsp_route", DW'(bus.rsp_tvalid), DW'(owner_model));
                check("res_tready", DW'(bus.res_tready), DW'(|(owner_model & bus.rsp_tready)));
            end
            if (bus.ctl_tvalid && bus.ctl_tready) begin
                if (exp_ctl.size() == 0) begin
                    fail("ctl_unexpected_beat", 1, 0);
                end else begin
                    ce = exp_ctl.pop_front();
                    check("ctl_grant", DW'(grant), DW'(ce.oh));
                    check("ctl_cmd",   DW'(bus.ctl_cmd), DW'(ce.cmd));
                    check("ctl_data",  bus.ctl_tdata, ce.data);
                    owner_model = ce.oh;
                    if (ce.last) in_drain = 1'b1;
                end
            end
            if (bus.res_tvalid && bus.res_tready) begin
                if (exp_rsp.size() == 0) begin
                    fail("rsp_unexpected_beat", 1, 0);
                end else begin
                    re = exp_rsp.pop_front();
                    check("rsp_tvalid", DW'(bus.rsp_tvalid), DW'(re.oh));
                    check("rsp_tdata",  bus.rsp_tdata, re.data);
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        clear_env();
        done_prev = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("rst");

        // All four requesters at once from reset: order 0,1,2,3
        run_round(NR'(4'b1111), 0, 1'b0);
        // Single requester 0, key + two blocks
        run_round(NR'(4'b0001), 3, 1'b0);

        // ctl_done while idle is a protocol error and nothing else
        @(posedge clk);
        #1;
        done_probe   = 1'b1;
        bus.ctl_done = 1'b1;
        @(posedge clk);
        #1;
        bus.ctl_done = 1'b0;
        done_probe   = 1'b0;
        model_perr   = 1'b1;
        @(negedge clk);
        check("probe_proto_err", DW'(proto_err), DW'(1'b1));
        check("probe_busy",      DW'(busy), '0);
        check("probe_grant",     DW'(grant), '0);
        check("probe_job_cnt",   DW'(job_cnt), DW'(16'(model_cnt)));

        for (int r = 0; r < 30; r++) run_round(NR'($urandom_range(1, (1 << NR) - 1)), 0, 1'b0);

        // Reset while draining abandons the job
        run_round(NR'(4'b0010), 3, 1'b1);
        reset = 1'b1;
        clear_env();
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("drain_rst");
        @(posedge clk);
        #1 reset = 1'b0;
        run_round(NR'($urandom_range(1, (1 << NR) - 1)), 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
